// File: rtl/vector_control_unit.sv
// Decode-stage control: one-cycle scalar decode plus a beat sequencer for vector ops (Op=11).
// Optional VEC_PERF_EN adds a saturating 32-bit StallCount output.
module vector_control_unit #(
  parameter int VLEN   = 8,
  parameter int LANES  = 4,
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ValidD,
  input  logic [1:0]               Op,
  input  logic [5:0]               Funct,
  input  logic [REG_AW-1:0]        Rd,
  input  logic                     MemReady,
  output logic                     PCSrcD,
  output logic                     RegWriteD,
  output logic                     MemToRegD,
  output logic                     MemWriteD,
  output logic                     BranchD,
  output logic                     ALUSrcD,
  output logic                     NoWrite,
  output logic                     ImmSrcD,
  output logic [1:0]               RegSrcD,
  output logic [3:0]               ALUControlD,
  output logic                     StallD,
  output logic                     VecBusy,
  output logic                     VecRegWrite,
  output logic                     VecMemWrite,
  output logic                     VecMemRead,
  output logic [$clog2(VLEN)-1:0]  ElemIdx,
  output logic [LANES-1:0]         LaneMask,
`ifdef VEC_PERF_EN
  output logic [31:0]              StallCount,
`endif
  output logic                     VecIllegal
);
  localparam int BEATS = (VLEN + LANES - 1) / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EW    = $clog2(VLEN);

  typedef enum logic [1:0] {IDLE, VALU, VMEM} state_t;

  state_t        state, state_n;
  logic [BW-1:0] beat, beat_n;
  logic [1:0]    vop;
  logic          vst;
  logic          is_vec, legal, accept, last, done;

  assign is_vec     = (state == IDLE) && ValidD && (Op == 2'b11);
  assign legal      = (Funct[5:4] == 2'b00) ? !Funct[3] : (Funct[5:4] != 2'b11);
  assign accept     = is_vec && legal;
  assign VecIllegal = is_vec && !legal;
  assign last       = (beat == BW'(BEATS - 1));
  assign done       = (state == VALU) || ((state == VMEM) && MemReady);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      beat  <= '0;
      vop   <= '0;
      vst   <= 1'b0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
      if (accept) begin
        vop <= Funct[2:1];
        vst <= Funct[5];
      end
    end
  end

  always_comb begin
    state_n = state;
    beat_n  = beat;
    if (accept) begin
      state_n = (Funct[5:4] == 2'b00) ? VALU : VMEM;
      beat_n  = '0;
    end else if (done) begin
      state_n = last ? IDLE : state;
      beat_n  = last ? '0 : beat + BW'(1);
    end
  end

  always_comb begin
    RegWriteD   = 1'b0;
    MemToRegD   = 1'b0;
    MemWriteD   = 1'b0;
    BranchD     = 1'b0;
    ALUSrcD     = 1'b0;
    NoWrite     = 1'b0;
    ImmSrcD     = 1'b0;
    RegSrcD     = 2'b00;
    ALUControlD = 4'b0000;
    VecRegWrite = 1'b0;
    VecMemWrite = 1'b0;
    VecMemRead  = 1'b0;
    ElemIdx     = '0;
    LaneMask    = '0;
    if (state == IDLE && ValidD) begin
      case (Op)
        2'b00: begin
          RegWriteD = 1'b1;
          ALUSrcD   = Funct[5];
          case (Funct[4:1])
            4'b0100: ALUControlD = 4'b0000;
            4'b0010: ALUControlD = 4'b0001;
            4'b0000: ALUControlD = 4'b0010;
            4'b1100: ALUControlD = 4'b0011;
            4'b1101: ALUControlD = 4'b0110;
            4'b1010: begin
              ALUControlD = 4'b0001;
              NoWrite     = 1'b1;
            end
            default: RegWriteD = 1'b0;
          endcase
        end
        2'b01: begin
          ALUSrcD     = 1'b1;
          ImmSrcD     = 1'b1;
          ALUControlD = Funct[5] ? 4'b0000 : 4'b0001;
          if (Funct[0]) begin
            RegWriteD = 1'b1;
            MemToRegD = 1'b1;
          end else begin
            MemWriteD = 1'b1;
            RegSrcD   = 2'b10;
          end
        end
        2'b10: begin
          BranchD = 1'b1;
          ALUSrcD = 1'b1;
          ImmSrcD = 1'b1;
          RegSrcD = 2'b01;
        end
        default: ;
      endcase
    end
    if (state != IDLE) begin
      // Beat outputs: element window and tail mask for the current beat
      ElemIdx = EW'(int'(beat) * LANES);
      for (int i = 0; i < LANES; i++)
        LaneMask[i] = (int'(beat) * LANES + i) < VLEN;
      if (state == VALU) begin
        VecRegWrite = 1'b1;
        ALUControlD = {2'b00, vop};
      end else begin
        VecMemRead  = !vst;
        VecMemWrite = vst;
        VecRegWrite = !vst;
      end
    end
  end

  assign PCSrcD  = ((Rd == {REG_AW{1'b1}}) && RegWriteD) || BranchD;
  assign VecBusy = (state != IDLE);
  assign StallD  = accept || (VecBusy && !(last && done));

`ifdef VEC_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      StallCount <= '0;
    else if (StallD && (StallCount != '1))
      StallCount <= StallCount + 32'd1;
  end
`endif

endmodule

// File: doc/vector_control_unit.md
Name: vector_control_unit

Overview:
- Next-generation decode-stage control unit: scalar decode of Op 00/01/10 (one cycle), plus multi-cycle sequencing for vector instructions (Op=11).
- Splits each vector instruction into ceil(VLEN/LANES) beats, producing per-beat element index, lane mask and write strobes.
- Stalls fetch/decode until the final beat issues.
- Sits in Decode, between the instruction register and the ID/EX pipeline register.

Parameters:
- VLEN, 8, elements per vector register (>=2)
- LANES, 4, elements processed per beat (1..VLEN)
- REG_AW, 5, register address width; PC register = all ones

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ValidD  in  1  decode-stage instruction valid
- Op  in  2  opcode class
- Funct  in  6  function field
- Rd  in  REG_AW  destination register
- MemReady  in  1  vector memory beat accepted
- PCSrcD  out  1  PC redirect
- RegWriteD, MemToRegD, MemWriteD, BranchD, ALUSrcD, NoWrite, ImmSrcD  out  1 each  scalar controls
- RegSrcD  out  2  register source select
- ALUControlD  out  4  ALU operation (scalar or vector)
- StallD  out  1  hold fetch/decode
- VecBusy  out  1  sequencer not IDLE
- VecRegWrite  out  1  vector register write this beat
- VecMemWrite  out  1  vector store beat
- VecMemRead  out  1  vector load beat
- ElemIdx  out  $clog2(VLEN)  first element of current beat
- LaneMask  out  LANES  active lanes this beat
- VecIllegal  out  1  one-cycle pulse on reserved vector encoding

Behaviour:
- Scalar decode (combinational; active only when the state is IDLE and ValidD=1, else all zero):
  - Op00: DP. Funct[5]=1 is immediate (ALUSrcD=1). RegWriteD=1.
  - ALU map on Funct[4:1]: 0100 ADD=0000; 0010 SUB=0001; 0000 MUL=0010; 1100 ORR=0011; 1101 MOV=0110; 1010 CMP=0001 with NoWrite=1; others ALUControlD=0000 and RegWriteD=0.
  - Op01: Funct[0]=1 is LDR (RegWriteD, MemToRegD, ALUSrcD, ImmSrcD=1). Funct[0]=0 is STR (MemWriteD, ALUSrcD, ImmSrcD=1, RegSrcD=10). ALU add if Funct[5]=1, else sub.
  - Op10: BranchD=1, ALUSrcD=1, ImmSrcD=1, RegSrcD=01, ALU add.
  - PCSrcD = (Rd==all ones & RegWriteD) | BranchD.
- Vector decode (Op=11), Funct[5:4]:
  - 00: VALU, op Funct[3:1]: 000 VADD=0000, 001 VSUB=0001, 010 VMUL=0010, 011 VOR=0011; 1xx is illegal.
  - 01: VLD. 10: VST. 11: illegal.
- FSM states: IDLE, VALU, VMEM.
  - IDLE -> VALU or VMEM on ValidD & Op=11 & legal. On that cycle (the accept cycle), latch op and kind, and clear the beat counter.
  - Illegal encoding: VecIllegal=1 for that cycle only, no transition, StallD=0.
- Beats: B = ceil(VLEN/LANES). Beat k has ElemIdx=k*LANES; LaneMask bit i = (k*LANES+i < VLEN).
  - VALU: one beat per cycle; VecRegWrite=1 each beat.
  - VMEM: beat held (outputs stable) until MemReady=1, then advance. VecMemRead (VLD) or VecMemWrite (VST) is high during each beat; VecRegWrite=VecMemRead.
  - A beat completes on the cycle it is presented (VALU) or when MemReady=1 (VMEM). Last beat completes -> IDLE next cycle.
  - ALUControlD holds the latched vector op during VALU beats, 0000 during VMEM.
- Stall: StallD = accept cycle | (state!=IDLE & !(last beat completing)). With MemReady=1 throughout, a B-beat op has accept cycle 0, beats in cycles 1..B, and StallD high in cycles 0..B-1. Decode inputs are ignored while not IDLE.
- VecBusy = state!=IDLE.
- Outputs outside beats: VecRegWrite, VecMemRead, VecMemWrite, ElemIdx and LaneMask are all 0.
- Reset (async, any time, including mid-sequence): state IDLE, beat counter 0, all registered outputs 0, VecIllegal 0. Any in-flight vector op is abandoned.

Optional Feature:
- VEC_PERF_EN defined: adds output StallCount (32 bits), reset to 0, incremented each cycle StallD=1, saturating at all ones.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Scalar Op=00, Funct=101000, Rd=31, ValidD=1 -> ALUControlD=0000, RegWriteD=1, ALUSrcD=1, PCSrcD=1, StallD=0.
- VADD (Op=11, Funct=000000), VLEN=8, LANES=4 -> StallD=1 for 2 cycles; beats ElemIdx 0 then 4, LaneMask 1111 both, VecRegWrite=1; IDLE in cycle 3.
- VLEN=10, LANES=4, VADD -> 3 beats, ElemIdx 0/4/8, last LaneMask=0011.
- VST with MemReady low for 2 cycles on beat 0 -> ElemIdx stays 0, VecMemWrite held; total stall = 1+2+2-1 cycles; VecRegWrite=0 throughout.
- Op=11, Funct=110000 -> VecIllegal pulse 1 cycle, StallD=0, state IDLE.
- Reset asserted mid-VLD beat 1 -> outputs 0 immediately; after release, ValidD=0 -> VecBusy=0 and StallD=0 (with VEC_PERF_EN: StallCount=0).
